// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, pointer-width helper and parameter legality check for the FIFO family
package fifo_pkg;
   localparam int FIFO_DEFAULT_WIDTH = 16;
   localparam int FIFO_DEFAULT_DEPTH = 32;
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic bit params_ok(input int depth, input int af, input int ae);
      return depth >= 2 && (depth & (depth - 1)) == 0 && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
   endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: WIDTH x DEPTH storage, one synchronous write port and one asynchronous read port
module fifo_mem_2p #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   // store the write word; no reset so this can map onto a RAM macro
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised show-ahead single-clock FIFO with count, thresholds, flush; sticky error flags when SYNC_FIFO_PARAM_ERR_EN is defined
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     write,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     read,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

   if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
      $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
   end

   logic [PW-1:0] wp, rp;
   logic          rd_ok, wr_ok;

   assign empty        = wp == rp;
   assign full         = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
   assign count        = wp - rp;
   assign almost_full  = count >= AF_L;
   assign almost_empty = count <= AE_L;
   assign rd_ok        = read && !empty;
   assign wr_ok        = write && (!full || read);

   // pointers: natural binary wrap, flush beats any same-cycle read/write
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (rd_ok) rp <= rp + 1'b1;
      end

   fifo_mem_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (wr_ok && !flush),
      .waddr (wp[AW-1:0]),
      .wdata (data_in),
      .raddr (rp[AW-1:0]),
      .rdata (data_out)
   );

`ifdef SYNC_FIFO_PARAM_ERR_EN
   logic ovf_q, unf_q;
   // sticky error flags, cleared only by reset or flush
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (flush) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (write && full && !read) ovf_q <= 1'b1;
         if (read && empty) unf_q <= 1'b1;
      end
   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param (default 16 x 32 configuration)
module tb_sync_fifo_param;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        full, empty, almost_full, almost_empty, overflow, underflow;
   logic [5:0]  count;

   int          checks = 0;
   int          errors = 0;
   int          occ = 0;
   logic [15:0] q[$];
`ifdef SYNC_FIFO_PARAM_ERR_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   sync_fifo_param dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .write        (write),
      .data_in      (data_in),
      .read         (read),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock cycle of stimulus; expected pops are queued when the write is issued
   task automatic step(input logic w, input logic r, input logic [15:0] d, input logic f);
      bit wa, ra;
      write = w; read = r; data_in = d; flush = f;
      if (f) begin
         q.delete();
         occ = 0;
      end else begin
         wa = w && (occ < 32 || r);
         ra = r && occ > 0;
         if (wa) q.push_back(d);
         occ = occ + int'(wa) - int'(ra);
      end
      @(posedge clk);
      #1;
      write = 1'b0; read = 1'b0; flush = 1'b0;
      chk("count_vs_model", int'(count), occ);
   endtask

   // monitor: every accepted pop must present the oldest expected word
   initial forever begin
      @(negedge clk);
      if (!reset && !flush && read && !empty) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_order: got 0x%0h expected nothing queued", data_out);
         end else chk("pop_order", int'(data_out), int'(q.pop_front()));
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_ae", int'(almost_empty), 1);
      chk("rst_af", int'(almost_full), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_unf", int'(underflow), 0);
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b0, 16'(i), 1'b0);
         chk("fill_count", int'(count), i + 1);
         chk("fill_af", int'(almost_full), int'(i + 1 >= 30));
         chk("fill_ae", int'(almost_empty), int'(i + 1 <= 2));
         chk("fill_head", int'(data_out), 0);
         chk("fill_full", int'(full), int'(i == 31));
      end
      step(1'b1, 1'b0, 16'hDEAD, 1'b0);
      chk("ovf_count", int'(count), 32);
      chk("ovf_flag", int'(overflow), ERR_EN);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0);
         chk("rw_full_count", int'(count), 32);
         chk("rw_full_full", int'(full), 1);
      end
      chk("rw_full_head", int'(data_out), 16'h000A);
      for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
      chk("drain_empty", int'(empty), 1);
      chk("drain_count", int'(count), 0);
      chk("drain_unf", int'(underflow), 0);
      step(1'b0, 1'b1, 16'h0, 1'b0);
      chk("unf_empty", int'(empty), 1);
      chk("unf_count", int'(count), 0);
      chk("unf_flag", int'(underflow), ERR_EN);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("unf_sticky", int'(underflow), ERR_EN);
      step(1'b1, 1'b1, 16'h0AAA, 1'b0);
      chk("rw_empty_count", int'(count), 1);
      chk("rw_empty_head", int'(data_out), 16'h0AAA);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'h0200 + 16'(i), 1'b0);
      chk("stream_count", int'(count), 1);
      chk("stream_head", int'(data_out), 16'h0227);
      step(1'b0, 1'b1, 16'h0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0300 + 16'(i), 1'b0);
      chk("pre_flush_count", int'(count), 5);
      step(1'b1, 1'b0, 16'hBEEF, 1'b1);
      chk("flush_empty", int'(empty), 1);
      chk("flush_count", int'(count), 0);
      chk("flush_ovf", int'(overflow), 0);
      chk("flush_unf", int'(underflow), 0);
      step(1'b1, 1'b0, 16'h0055, 1'b0);
      chk("post_flush_head", int'(data_out), 16'h0055);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0400 + 16'(i), 1'b0);
      chk("pre_rst_count", int'(count), 7);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_empty", int'(empty), 1);
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_full", int'(full), 0);
      q.delete();
      occ = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      step(1'b1, 1'b0, 16'h0777, 1'b0);
      chk("post_rst_head", int'(data_out), 16'h0777);
      step(1'b0, 1'b1, 16'h0, 1'b0);
      chk("final_empty", int'(empty), 1);
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
